// File: rtl/acq_engine.sv
// Acquisition engine: divides the clock into ADC sample ticks, streams samples into a
// circular sample RAM, and evaluates level/edge, external, forced and timeout triggers.
module acq_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              activate,
    input  logic [DIV_W-1:0]  div,
    input  logic [ADDR_W-1:0] pre_cnt,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_ext,
    input  logic              force_trig,
    input  logic              auto_en,
    output logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              trig_auto
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_l;
    logic [ADDR_W-1:0] pre_l;
    logic [DATA_W-1:0] lvl_l;
    logic              edge_l;
    logic              auto_l;
    logic [ADDR_W-1:0] wp;
    logic [CNT_W-1:0]  scnt;
    logic [CNT_W-1:0]  acnt;
    logic [DATA_W-1:0] prev;
    logic              prev_vld;

    logic [DIV_W-1:0]  d_eff;
    logic              tick;
    logic              int_trig;
    logic              real_trig;
    logic              auto_hit;
    logic [CNT_W-1:0]  post_len;

    assign busy     = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
    assign done     = (state == S_DONE);
    assign d_eff    = (div_l == '0) ? DIV_W'(1) : div_l;
    assign tick     = busy && (cnt == d_eff);
    assign post_len = CNT_W'(DEPTH - 1) - CNT_W'(pre_l);

    // The previous sample is meaningless until one sample of this capture exists.
    assign int_trig = prev_vld && (edge_l ? (prev > lvl_l && adc_data <= lvl_l)
                                          : (prev < lvl_l && adc_data >= lvl_l));
    assign real_trig = int_trig || trig_ext || force_trig;
    assign auto_hit  = auto_l && (acnt == CNT_W'(DEPTH - 1));

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            div_l      <= '0;
            pre_l      <= '0;
            lvl_l      <= '0;
            edge_l     <= 1'b0;
            auto_l     <= 1'b0;
            wp         <= '0;
            scnt       <= '0;
            acnt       <= '0;
            prev       <= '0;
            prev_vld   <= 1'b0;
            adc_clk    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            start_addr <= '0;
            trig_addr  <= '0;
            trig_auto  <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            adc_clk <= 1'b0;
            cnt     <= (busy && !tick) ? cnt + DIV_W'(1) : '0;

            // A tick coinciding with an abort is dropped so nothing is written after it.
            if (tick && activate) begin
                adc_clk  <= 1'b1;
                mem_we   <= 1'b1;
                mem_addr <= wp;
                mem_data <= adc_data;
                wp       <= wp + ADDR_W'(1);
                prev     <= adc_data;
                prev_vld <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (activate) begin
                        div_l     <= div;
                        pre_l     <= pre_cnt;
                        lvl_l     <= trig_level;
                        edge_l    <= trig_edge;
                        auto_l    <= auto_en;
                        wp        <= '0;
                        scnt      <= '0;
                        acnt      <= '0;
                        prev_vld  <= 1'b0;
                        trig_auto <= 1'b0;
                        state     <= (pre_cnt == '0) ? S_ARMED : S_FILL;
                    end
                end
                S_FILL: begin
                    if (!activate) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (scnt + CNT_W'(1) == CNT_W'(pre_l)) begin
                            scnt  <= '0;
                            state <= S_ARMED;
                        end else begin
                            scnt <= scnt + CNT_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (!activate) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (real_trig || auto_hit) begin
                            trig_addr  <= wp;
                            start_addr <= wp - pre_l;
                            trig_auto  <= !real_trig;
                            scnt       <= '0;
                            state      <= S_POST;
                        end else begin
                            acnt <= acnt + CNT_W'(1);
                        end
                    end
                end
                S_POST: begin
                    // Finish on the edge closing the final write; ticks never coincide with a write.
                    if (!activate) begin
                        state <= S_IDLE;
                    end else begin
                        if (tick)
                            scnt <= scnt + CNT_W'(1);
                        if (mem_we && scnt == post_len)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!activate)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/acq_engine.md
# acq_engine

Parametrised acquisition engine: the next-generation sampler that drives the ADC, streams samples into the sample RAM as a circular buffer, and evaluates its own level/edge trigger. It sits between the ADC front end and the sample RAM and is controlled by the top-level state logic through an `activate`/`done` level handshake. Over the previous sampler it adds the following:

- a programmable sample-rate divider, used as a clock enable rather than a derived clock;
- a programmable pre-trigger depth;
- an internal edge trigger, plus an external trigger input;
- auto-trigger timeout;
- abort;
- reporting of the oldest-sample address, so readout can linearise the buffer without shifting memory.

## Interface

Parameters:

- `DATA_W`, default 8: ADC sample width.
- `ADDR_W`, default 8: RAM address width. Buffer depth is DEPTH = 2^ADDR_W.
- `DIV_W`, default 16: width of the divider setting.

Ports (one clock, `clk_50mhz`; reset is asynchronous and active-low, port `reset`):

- `clk_50mhz` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `activate` in 1: level. Rising into 1 while idle starts a capture; dropping to 0 aborts or acknowledges.
- `div` in DIV_W: sample period is max(div,1)+1 clocks. Latched at start.
- `pre_cnt` in ADDR_W: number of samples stored before the trigger sample. Latched at start.
- `trig_level` in DATA_W: internal trigger threshold, unsigned. Latched at start.
- `trig_edge` in 1: 0 selects rising, 1 selects falling. Latched at start.
- `trig_ext` in 1: synchronous external trigger, already synchronised upstream.
- `force_trig` in 1: immediate trigger.
- `auto_en` in 1: enable auto-trigger timeout. Latched at start.
- `adc_clk` out 1: registered ADC conversion clock.
- `adc_data` in DATA_W: ADC output.
- `mem_we` out 1: one-cycle write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_data` out DATA_W: write data.
- `busy` out 1: high in FILL, ARMED and POST.
- `done` out 1: high in DONE.
- `start_addr` out ADDR_W: address of the oldest sample in the buffer.
- `trig_addr` out ADDR_W: address of the trigger sample.
- `trig_auto` out 1: the capture was triggered by timeout.

## Operation

- Sample tick:
  - Divider counter `cnt` runs 0..D, where D = max(div_latched,1), only while busy.
  - A tick occurs in the cycle where `cnt`==D.
  - `adc_data` is captured on the tick edge.
  - `adc_clk` is registered high for exactly the one cycle after each tick, and is 0 otherwise and whenever not busy.
- Storage: every tick in FILL, ARMED or POST produces one write on the next cycle.
  - `mem_we`=1 for that cycle, with the captured sample on `mem_data` and address `wp` on `mem_addr`.
  - `wp` then increments modulo DEPTH.
  - `wp` resets to 0 at each start.
- Internal trigger:
  - Compares the previous sample p with the current sample c at each tick.
  - Rising edge fires when p < level and c >= level.
  - Falling edge fires when p > level and c <= level.
  - p is invalid for the first sample after start, so no internal trigger can fire on that sample.
- A trigger is the OR of the internal trigger, `trig_ext` and `force_trig`. It is evaluated only on ticks in ARMED. `trig_ext` and `force_trig` are sampled only on ticks.
- States:
  - IDLE: goes to FILL when `activate`=1. Latches settings, clears `cnt`, `wp`, the sample counter and `trig_auto`.
  - FILL: stores pre_cnt samples, ignoring triggers. Goes to ARMED after the pre_cnt-th tick. If pre_cnt=0, FILL is skipped and IDLE goes directly to ARMED.
  - ARMED: stores circularly. On a trigger tick:
    - trig_addr = that sample's address;
    - start_addr = trig_addr − pre_cnt (mod DEPTH);
    - go to POST.
  - ARMED auto timeout: with `auto_en`=1, if the DEPTH-th tick spent in ARMED has no trigger, that tick is treated as a trigger and `trig_auto`=1. A real trigger on the same tick wins and `trig_auto`=0.
  - POST: stores DEPTH−1−pre_cnt further samples, then goes to DONE. If that count is 0, it goes to DONE right after the trigger sample's write.
  - DONE: `done`=1, no writes. Goes to IDLE when `activate`=0.
- Abort: `activate`=0 in FILL, ARMED or POST goes to IDLE on the next clock.
  - No further `mem_we` after the one possibly already in flight.
  - `done` stays 0.
  - `start_addr`, `trig_addr` and `trig_auto` keep their previous values.
- Reset, asserted at any time, forces IDLE immediately. All of the following go to 0: every output, `cnt`, `wp`, and the sample counters.
- Address arithmetic is ADDR_W-bit unsigned with natural wrap. Counters are ADDR_W+1 bits so that a count of DEPTH is representable.

## Timing

- Tick to `mem_we` latency: 1 clock. Tick to `adc_clk` high: 1 clock.
- With D=1, a tick occurs every 2 clocks and `adc_clk` has a 50% duty cycle.
- Last POST write to `done`=1: `done` rises on the clock edge that ends the last write cycle.
- The `activate` rise is seen on the next edge. The first tick comes D+1 clocks after the IDLE→FILL transition.
- `start_addr` and `trig_addr` update on the trigger tick edge and are stable while `done`=1.

## Test plan

- **Ramp capture.** ADDR_W=4, div=1, pre_cnt=4, rising edge, level=10, ADC ramp 0,1,2,… per tick. Required:
  - trigger on sample 10, with trig_addr=10 and start_addr=6;
  - 22 `mem_we` pulses in total;
  - final RAM reads back 6..21 at addresses 6..5 wrapped;
  - `done`=1 and `trig_auto`=0.
- **Falling edge, first sample.** Falling edge, level=5, ramp starting at 9 descending. Required:
  - no trigger on the first sample, even if it is ≤5;
  - trigger at value 5.
  - Also: with the first sample already at 3, trigger at the first subsequent crossing only.
- **Auto trigger.** `auto_en`=1, constant data, pre_cnt=0, ADDR_W=4. Required:
  - trigger on the 16th ARMED tick, with `trig_auto`=1;
  - exactly 16+15=31 writes;
  - start_addr=trig_addr=15.
  - Repeat with `force_trig` on that same tick: `trig_auto`=0.
- **Abort.** Drop `activate` mid-ARMED. Required: IDLE next clock, no further `mem_we`, `done` never rises. A restart then begins writing at address 0.
- **Reset mid-POST.** Assert `reset` mid-POST. Required: `mem_we`, `adc_clk`, `busy`, `done`, `start_addr` and `trig_addr` all go to 0 asynchronously, before the next clock edge.
- **Boundary.** pre_cnt=DEPTH−1 with `force_trig` held. Required:
  - trigger on the first ARMED tick;
  - POST length 0;
  - DEPTH writes in total;
  - `done`=1 one cycle after the last write.
